irq_source_ctrl: RTL

Interrupt source controller that sits directly upstream of the processor's interrupt inputs. It synchronises and debounces the pushbutton, and buffers inbound Ethernet receive words in a small FIFO. It arbitrates the two sources and presents one interrupt at a time on interrupt_key / interrupt_eth, with its payload on interrupt_source_data. The processor acknowledges the payload read with irq_ack (RDI) and ends the handler with irq_done (RTI/RSI).

---
 rtl/irq_source_ctrl.sv | 155 +++++++++++++++
 1 files changed

// File: rtl/irq_source_ctrl.sv
// Interrupt source controller: debounced pushbutton plus Ethernet receive FIFO, arbitrated
// into one interrupt at a time. Define IRQ_DROP_CNT_EN to add the drop_count port.
module irq_source_ctrl #(
  parameter int unsigned DEBOUNCE_CYCLES = 16,
  parameter int unsigned FIFO_DEPTH      = 4,
  parameter logic [31:0] KEY_CODE        = 32'h0000_0001
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        key_raw,
  input  logic        eth_valid,
  input  logic [31:0] eth_data,
  output logic        eth_ready,
  input  logic        irq_ack,
  input  logic        irq_done,
`ifdef IRQ_DROP_CNT_EN
  output logic [15:0] drop_count,
`endif
  output logic        interrupt_key,
  output logic        interrupt_eth,
  output logic [31:0] interrupt_source_data
);

  localparam int unsigned AW = $clog2(FIFO_DEPTH);
  localparam int unsigned CW = $clog2(DEBOUNCE_CYCLES + 1);

  typedef enum logic [1:0] {StIdle, StKey, StEth, StWait} state_e;

  state_e        state_q, state_d;
  logic          sync1_q, sync2_q;
  logic          deb_q, deb_d, deb_prev_q;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          key_pend_q, key_pend_d;
  logic          key_rise;
  logic [AW:0]   wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [31:0]   mem_q [FIFO_DEPTH];
  logic          full, empty, push, pop;
  logic          irq_key_q, irq_eth_q;
  logic [31:0]   data_q, data_d;

  // Counter tracks how long the synchronised level has disagreed with the debounced one.
  always_comb begin
    cnt_d = cnt_q;
    deb_d = deb_q;
    if (sync2_q == deb_q) begin
      cnt_d = '0;
    end else if (cnt_q == CW'(DEBOUNCE_CYCLES - 1)) begin
      deb_d = sync2_q;
      cnt_d = '0;
    end else begin
      cnt_d = cnt_q + CW'(1);
    end
  end

  assign key_rise = deb_q & ~deb_prev_q;

  assign full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign empty = (wr_ptr_q == rd_ptr_q);
  assign push  = eth_valid & ~full;
  assign pop   = (state_q == StEth) & irq_ack;

  always_comb begin
    wr_ptr_d = push ? wr_ptr_q + 1'b1 : wr_ptr_q;
    rd_ptr_d = pop  ? rd_ptr_q + 1'b1 : rd_ptr_q;
  end

  always_comb begin
    key_pend_d = key_pend_q;
    if (state_q == StKey && irq_ack) key_pend_d = 1'b0;
    if (key_rise)                    key_pend_d = 1'b1;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle: begin
        if (key_pend_q)  state_d = StKey;
        else if (!empty) state_d = StEth;
      end
      StKey:   if (irq_ack)  state_d = StWait;
      StEth:   if (irq_ack)  state_d = StWait;
      StWait:  if (irq_done) state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // Payload follows the next state so it lands on the same edge as the request.
  always_comb begin
    data_d = '0;
    if (state_d == StKey)      data_d = KEY_CODE;
    else if (state_d == StEth) data_d = mem_q[rd_ptr_q[AW-1:0]];
  end

  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q[AW-1:0]] <= eth_data;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1_q    <= 1'b0;
      sync2_q    <= 1'b0;
      deb_q      <= 1'b0;
      deb_prev_q <= 1'b0;
      cnt_q      <= '0;
      key_pend_q <= 1'b0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
    end else begin
      sync1_q    <= key_raw;
      sync2_q    <= sync1_q;
      deb_q      <= deb_d;
      deb_prev_q <= deb_q;
      cnt_q      <= cnt_d;
      key_pend_q <= key_pend_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= StIdle;
      irq_key_q <= 1'b0;
      irq_eth_q <= 1'b0;
      data_q    <= '0;
    end else begin
      state_q   <= state_d;
      irq_key_q <= (state_d == StKey);
      irq_eth_q <= (state_d == StEth);
      data_q    <= data_d;
    end
  end

  assign eth_ready             = ~full;
  assign interrupt_key         = irq_key_q;
  assign interrupt_eth         = irq_eth_q;
  assign interrupt_source_data = data_q;

`ifdef IRQ_DROP_CNT_EN
  logic [15:0] drop_cnt_q, drop_cnt_d;

  always_comb begin
    drop_cnt_d = drop_cnt_q;
    if (eth_valid && full && drop_cnt_q != 16'hFFFF) drop_cnt_d = drop_cnt_q + 16'd1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) drop_cnt_q <= '0;
    else     drop_cnt_q <= drop_cnt_d;
  end

  assign drop_count = drop_cnt_q;
`endif

endmodule
